// File: rtl/image_difference_accumulator_pkg.sv
// image_difference_accumulator_pkg: FSM states and width defaults shared by the SAD engine, its PIO wrapper and benches
package image_difference_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  localparam int PIXEL_W_DEF = 8;
  localparam int RESULT_W_DEF = 32;
  localparam int NUM_PIXELS_DEF = 784;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/image_difference_accumulator_abs_diff_stage.sv
// image_difference_accumulator_abs_diff_stage: registers |a-b| of an accepted pixel pair with its valid bit
module image_difference_accumulator_abs_diff_stage
  import image_difference_accumulator_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] a,
  input  logic [PIXEL_W-1:0] b,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_abs
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_abs <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_abs <= a > b ? a - b : b - a;
    end
endmodule

// File: rtl/image_difference_accumulator.sv
// image_difference_accumulator: streaming SAD of an image against a template, result held until the next frame completes
module image_difference_accumulator
  import image_difference_accumulator_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int RESULT_W = RESULT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [PIXEL_W-1:0]  pix_a,
  input  logic [PIXEL_W-1:0]  pix_b,
  output logic [RESULT_W-1:0] difference,
  output logic                busy,
  output logic                done,
  output logic                saturated
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [RESULT_W-1:0] acc;
  logic [RESULT_W:0] sum;
  logic [PIXEL_W-1:0] s1_abs;
  logic sat, s1_valid, accept, launch, last_beat, publish;
  assign pix_ready = state == ACCUM;
  assign busy = state == ACCUM || state == DRAIN;
  assign done = state == DONE;
  assign accept = pix_valid && pix_ready;
  assign launch = start && (state == IDLE || state == DONE);
  assign last_beat = accept && count == CNT_W'(NUM_PIXELS - 1);
  assign publish = state == DRAIN && !s1_valid;
  // One spare bit catches overflow so the accumulator can clamp instead of wrapping.
  assign sum = {1'b0, acc} + (RESULT_W + 1)'(s1_abs);
  image_difference_accumulator_abs_diff_stage #(.PIXEL_W(PIXEL_W)) u_abs_diff_stage (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(accept),
    .a(pix_a),
    .b(pix_b),
    .out_valid(s1_valid),
    .out_abs(s1_abs)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = launch ? ACCUM : last_beat ? DRAIN : publish ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      sat <= 1'b0;
      difference <= '0;
      saturated <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) count <= '0;
      else if (accept) count <= count + CNT_W'(1);
      if (launch) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (s1_valid) begin
        acc <= sum[RESULT_W] ? '1 : sum[RESULT_W-1:0];
        sat <= sat | sum[RESULT_W];
      end
      if (publish) begin
        difference <= acc;
        saturated <= sat;
      end
    end
endmodule

// File: tb/tb_image_difference_accumulator.sv
// tb_image_difference_accumulator: three parameterisations driven from a vector table plus random frames against a SAD model
module tb_image_difference_accumulator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] pix_valid = '0;
  logic [2:0] pix_ready, busy, done, saturated;
  logic [2:0][7:0] pix_a = '0;
  logic [2:0][7:0] pix_b = '0;
  logic [31:0] diff0, diff2;
  logic [9:0] diff1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_diff [3];

  typedef struct {
    string name;
    int d;
    int off;
    int gap;
    bit poke;
    logic [31:0] exp;
    bit sat;
  } vec_t;
  vec_t tv [6];
  int pa [26] = '{10, 3, 255, 7, 0, 0, 0, 0, 255, 255, 255, 255, 255, 255, 255, 255,
                  1, 1, 1, 1, 1, 1, 1, 1, 0, 255};
  int pb [26] = '{3, 10, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 255, 0};

  always #5 clk = ~clk;

  image_difference_accumulator #(.PIXEL_W(8), .NUM_PIXELS(4), .RESULT_W(32), .CNT_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
    .pix_a(pix_a[0]), .pix_b(pix_b[0]), .difference(diff0), .busy(busy[0]), .done(done[0]),
    .saturated(saturated[0]));
  image_difference_accumulator #(.PIXEL_W(8), .NUM_PIXELS(8), .RESULT_W(10), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
    .pix_a(pix_a[1]), .pix_b(pix_b[1]), .difference(diff1), .busy(busy[1]), .done(done[1]),
    .saturated(saturated[1]));
  image_difference_accumulator #(.PIXEL_W(8), .NUM_PIXELS(2), .RESULT_W(32), .CNT_W(16)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]),
    .pix_a(pix_a[2]), .pix_b(pix_b[2]), .difference(diff2), .busy(busy[2]), .done(done[2]),
    .saturated(saturated[2]));

  function automatic logic [31:0] diff_of(int d);
    return d == 0 ? diff0 : d == 1 ? {22'd0, diff1} : diff2;
  endfunction

  function automatic int nump(int d);
    return d == 0 ? 4 : d == 1 ? 8 : 2;
  endfunction

  function automatic longint maxv(int d);
    return d == 1 ? 64'd1023 : 64'hFFFF_FFFF;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(string name, int d);
    check({name, " difference"}, diff_of(d), 0);
    check({name, " done"}, 32'(done[d]), 0);
    check({name, " busy"}, 32'(busy[d]), 0);
    check({name, " saturated"}, 32'(saturated[d]), 0);
    check({name, " pix_ready"}, 32'(pix_ready[d]), 0);
  endtask

  // gap: 0 back-to-back, 1 valid on every third cycle, 2 random valid
  task automatic run_frame(string name, int d, int qa[$], int qb[$], int gap, bit poke,
                           logic [31:0] exp, bit exps);
    int i = 0;
    int c = 0;
    bit v, xfer;
    bit hold_bad = 0;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check({name, " busy after start"}, 32'(busy[d]), 1);
    while (i < qa.size() && c < 200) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      pix_valid[d] = v;
      pix_a[d] = 8'(qa[i]);
      pix_b[d] = 8'(qb[i]);
      start[d] = poke && i == 2;
      if (!pix_ready[d] || done[d] || diff_of(d) !== last_diff[d]) hold_bad = 1;
      xfer = v && pix_ready[d];
      @(negedge clk);
      if (xfer) i++;
      c++;
    end
    start[d] = 1'b0;
    check({name, " all beats accepted"}, 32'(i), 32'(qa.size()));
    pix_valid[d] = 1'b1;
    pix_a[d] = 8'd1;
    pix_b[d] = 8'd0;
    check({name, " ready drops after last beat"}, 32'(pix_ready[d]), 0);
    check({name, " busy in drain"}, 32'(busy[d]), 1);
    if (done[d] || diff_of(d) !== last_diff[d]) hold_bad = 1;
    @(negedge clk);
    check({name, " done not early"}, 32'(done[d]), 0);
    if (diff_of(d) !== last_diff[d]) hold_bad = 1;
    @(negedge clk);
    pix_valid[d] = 1'b0;
    check({name, " difference"}, diff_of(d), exp);
    check({name, " done"}, 32'(done[d]), 1);
    check({name, " busy"}, 32'(busy[d]), 0);
    check({name, " saturated"}, 32'(saturated[d]), 32'(exps));
    check({name, " result held during frame"}, 32'(hold_bad), 0);
    last_diff[d] = exp;
  endtask

  initial begin
    int qa[$];
    int qb[$];
    longint s;
    int d, a, b;
    for (int k = 0; k < 3; k++) last_diff[k] = 0;
    tv[0] = '{"basic", 0, 0, 0, 0, 269, 0};
    tv[1] = '{"gaps", 0, 0, 1, 0, 269, 0};
    tv[2] = '{"restart", 0, 4, 1, 1, 0, 0};
    tv[3] = '{"saturate", 1, 8, 0, 0, 1023, 1};
    tv[4] = '{"unsaturate", 1, 16, 1, 0, 8, 0};
    tv[5] = '{"unsigned", 2, 24, 0, 0, 510, 0};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle($sformatf("reset dut%0d", k), k);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle($sformatf("post-reset dut%0d", k), k);
    for (int t = 0; t < 6; t++) begin
      qa = {};
      qb = {};
      for (int i = 0; i < nump(tv[t].d); i++) begin
        qa.push_back(pa[tv[t].off + i]);
        qb.push_back(pb[tv[t].off + i]);
      end
      run_frame(tv[t].name, tv[t].d, qa, qb, tv[t].gap, tv[t].poke, tv[t].exp, tv[t].sat);
    end
    for (int r = 0; r < 9; r++) begin
      d = r % 3;
      qa = {};
      qb = {};
      s = 0;
      for (int i = 0; i < nump(d); i++) begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        qa.push_back(a);
        qb.push_back(b);
        s += a > b ? a - b : b - a;
      end
      run_frame($sformatf("random%0d dut%0d", r, d), d, qa, qb, 2, 0,
                32'(s > maxv(d) ? maxv(d) : s), s > maxv(d));
    end
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    pix_valid[0] = 1'b1;
    pix_a[0] = 8'd9;
    pix_b[0] = 8'd2;
    repeat (2) @(negedge clk);
    pix_valid[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_idle($sformatf("mid-frame reset dut%0d", k), k);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("after abort dut0", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
